led_pattern_sequencer: RTL and testbench

Controller that schedules the LED pattern datapath on the Genesys2 board. It synchronizes and debounces the user switches and generates the step tick. It then arbitrates between manual mode selection and an automatic mode rotation, and applies one pattern operation to the LED register per tick. It sits between the board switch pins and the LED pins, and replaces ad-hoc switch decoding inside the pattern register.

---
 rtl/led_pattern_sequencer.sv | 95 +++++++++
 tb/tb_led_pattern_sequencer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer: debounced switch mode select, auto mode rotation and tick-driven LED pattern register
module led_pattern_sequencer #(
    parameter int LED_SIZE        = 8,
    parameter int SW_SIZE         = 8,
    parameter int TICK_DIV        = 100_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int DWELL_STEPS     = 16,
    parameter int CNT_W           = 28
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SW_SIZE-1:0]  sw,
    output logic [LED_SIZE-1:0] led_out,
    output logic [2:0]          mode,
    output logic                auto_active,
    output logic                step_tick
);
    localparam int DW = $clog2(DWELL_STEPS + 1);
    localparam logic [2:0] M_COUNT = 3'd0, M_HOLD = 3'd1, M_ROTL = 3'd2, M_ROTR = 3'd3, M_INV = 3'd4;
    typedef enum logic [1:0] {S_AUTO, S_MANUAL, S_RELOAD} state_t;
    state_t state, state_nxt;
    logic [SW_SIZE-1:0] sw_meta, sw_sync, sw_prev, sw_db;
    logic [CNT_W-1:0] db_cnt, db_cnt_nxt, tick_cnt;
    logic [DW-1:0] dwell;
    logic db_chg, tick_end, dwell_end;
    logic [2:0] sw_mode, auto_nxt;
    logic [LED_SIZE-1:0] led_nxt;
    assign db_cnt_nxt = (sw_sync != sw_prev) ? CNT_W'(1) : db_cnt + 1'b1;
    assign tick_end   = tick_cnt == CNT_W'(TICK_DIV - 1);
    assign dwell_end  = dwell == DW'(DWELL_STEPS - 1);
    assign sw_mode    = (sw_db == SW_SIZE'(1)) ? M_HOLD :
                        (sw_db == SW_SIZE'(2)) ? M_ROTL :
                        (sw_db == SW_SIZE'(4)) ? M_ROTR :
                        (sw_db == SW_SIZE'(8)) ? M_INV  : M_COUNT;
    assign auto_nxt   = (mode == M_COUNT) ? M_ROTL :
                        (mode == M_ROTL)  ? M_ROTR :
                        (mode == M_ROTR)  ? M_INV  : M_COUNT;
    assign led_nxt    = (mode == M_COUNT) ? led_out + 1'b1 :
                        (mode == M_INV)   ? ~led_out :
                        (mode == M_ROTL || mode == M_ROTR) && led_out == '0 ? LED_SIZE'(1) :
                        (mode == M_ROTL)  ? {led_out[LED_SIZE-2:0], led_out[LED_SIZE-1]} :
                        (mode == M_ROTR)  ? {led_out[0], led_out[LED_SIZE-1:1]} : led_out;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sw_meta <= '0;
            sw_sync <= '0;
            sw_prev <= '0;
            sw_db   <= '0;
            db_cnt  <= '0;
            db_chg  <= 1'b0;
        end else begin
            sw_meta <= sw;
            sw_sync <= sw_meta;
            sw_prev <= sw_sync;
            db_chg  <= 1'b0;
            if (sw_sync == sw_db)
                db_cnt <= '0;
            else if (db_cnt_nxt >= CNT_W'(DEBOUNCE_CYCLES)) begin
                sw_db  <= sw_sync;
                db_cnt <= '0;
                db_chg <= 1'b1;
            end else
                db_cnt <= db_cnt_nxt;
        end
    always_comb begin
        state_nxt   = db_chg ? S_RELOAD : state;
        auto_active = state == S_AUTO;
        if (state == S_RELOAD && !db_chg)
            state_nxt = (sw_db == '0) ? S_AUTO : S_MANUAL;
    end
    // a tick that would land inside S_RELOAD is dropped; the counter restarts on exit
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state     <= S_AUTO;
            tick_cnt  <= '0;
            step_tick <= 1'b0;
            dwell     <= '0;
            mode      <= M_COUNT;
            led_out   <= '0;
        end else begin
            state     <= state_nxt;
            tick_cnt  <= (state == S_RELOAD || tick_end) ? '0 : tick_cnt + 1'b1;
            step_tick <= tick_end && state != S_RELOAD && state_nxt != S_RELOAD;
            if (step_tick)
                led_out <= led_nxt;
            if (state == S_RELOAD) begin
                dwell <= '0;
                mode  <= sw_mode;
            end else if (step_tick && state == S_AUTO) begin
                dwell <= dwell_end ? '0 : dwell + 1'b1;
                if (dwell_end)
                    mode <= auto_nxt;
            end
        end
endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb_led_pattern_sequencer: directed checks of reset, auto rotation, debounce, wraps, coincident reload and async reset
module tb_led_pattern_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    logic [7:0] sw = 8'h00;
    logic [7:0] led_out;
    logic [2:0] mode;
    logic auto_active, step_tick;
    int checks = 0, errors = 0, cyc = 0, t_last = 0, t_tick = 0, n;
    logic [7:0] p, e, start;
    logic wrapped;
    logic [7:0] auto_led [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h04, 8'h02, 8'hFD, 8'h02};
    logic [2:0] auto_mode [8] = '{3'd0, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4, 3'd0};

    led_pattern_sequencer #(
        .LED_SIZE(8), .SW_SIZE(8), .TICK_DIV(4), .DEBOUNCE_CYCLES(3), .DWELL_STEPS(2), .CNT_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sw(sw), .led_out(led_out),
        .mode(mode), .auto_active(auto_active), .step_tick(step_tick)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic wait_tick();
        t_last = t_tick;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (step_tick) break;
        end
        if (!step_tick) check("tick_timeout", step_tick, 1);
        t_tick = cyc;
    endtask

    task automatic wait_mode(input logic [2:0] m);
        for (int i = 0; i < 32 && mode != m; i++) @(negedge clk);
        if (mode != m) check("mode_timeout", mode, m);
    endtask

    // called on the sampled tick T; the switch change lands on tick T+8
    task automatic coincide(input logic [7:0] nsw, input logic [2:0] om, input logic [2:0] nm,
                            input logic [7:0] cpre, input logic [7:0] cpost, input logic [7:0] npost);
        repeat (3) @(negedge clk);
        sw = nsw;
        wait_tick();
        wait_tick();
        check("coin_mode_old", mode, om);
        check("coin_pre", led_out, cpre);
        @(negedge clk);
        check("coin_post", led_out, cpost);
        check("coin_reload", auto_active, 0);
        wait_tick();
        check("reload_to_tick", t_tick - t_last, 6);
        check("coin_mode_new", mode, nm);
        @(negedge clk);
        check("coin_next", led_out, npost);
    endtask

    initial begin
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_led", led_out, 0);
        check("rst_mode", mode, 0);
        check("rst_auto", auto_active, 1);
        check("rst_step", step_tick, 0);
        @(negedge clk);
        rst_n = 1'b1;
        t_tick = cyc;
        for (int i = 0; i < 8; i++) begin
            wait_tick();
            check("auto_period", t_tick - t_last, 4);
            @(negedge clk);
            check("auto_led", led_out, auto_led[i]);
            check("auto_mode", mode, auto_mode[i]);
            check("auto_active", auto_active, 1);
        end
        for (int i = 0; i < 10; i++) begin
            sw = (i % 2 == 1) ? 8'h00 : 8'h02;
            repeat (2) begin
                @(negedge clk);
                check("db_no_reload", auto_active, 1);
            end
        end
        sw = 8'h02;
        n = 0;
        while (auto_active && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("db_latency", n, 6);
        @(negedge clk);
        check("db_mode", mode, 2);
        check("db_manual", auto_active, 0);
        sw = 8'h03;
        wait_mode(3'd0);
        wait_tick();
        start = led_out;
        e = start;
        wrapped = 1'b0;
        for (int i = 0; i < 256; i++) begin
            if (i > 0) wait_tick();
            p = led_out;
            @(negedge clk);
            e = e + 8'd1;
            check("count_inc", led_out, e);
            if (p == 8'hFF && led_out == 8'h00) wrapped = 1'b1;
        end
        check("count_wrap_seen", wrapped, 1);
        check("count_return", led_out, start);
        for (int i = 0; i < 300; i++) begin
            wait_tick();
            if (led_out == 8'hFC) break;
        end
        check("seek_fc", led_out, 8'hFC);
        coincide(8'h08, 3'd0, 3'd4, 8'hFE, 8'hFF, 8'h00);
        for (int i = 0; i < 8; i++) begin
            wait_tick();
            if (led_out == 8'hFF) break;
        end
        check("seek_ff", led_out, 8'hFF);
        coincide(8'h01, 3'd4, 3'd1, 8'hFF, 8'h00, 8'h00);
        wait_tick();
        @(negedge clk);
        check("hold", led_out, 0);
        sw = 8'h02;
        wait_mode(3'd2);
        for (int i = 0; i < 9; i++) begin
            wait_tick();
            @(negedge clk);
            e = 8'h01 << (i % 8);
            check("rotl", led_out, e);
        end
        sw = 8'h04;
        wait_mode(3'd3);
        wait_tick();
        p = led_out;
        @(negedge clk);
        e = {p[0], p[7:1]};
        check("rotr", led_out, e);
        #2 rst_n = 1'b0;
        #1;
        check("arst_led", led_out, 0);
        check("arst_mode", mode, 0);
        check("arst_auto", auto_active, 1);
        check("arst_step", step_tick, 0);
        sw = 8'h00;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        t_tick = cyc;
        wait_tick();
        check("restart_period", t_tick - t_last, 4);
        @(negedge clk);
        check("restart_led1", led_out, 1);
        check("restart_mode1", mode, 0);
        wait_tick();
        @(negedge clk);
        check("restart_led2", led_out, 2);
        check("restart_mode2", mode, 2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
